frame_reader: RTL

- Read side of the pre-emphasis sample FIFO. Pops pre-emphasised samples whenever the FIFO is not empty and the block needs input.
- Assembles overlapping frames, FRAME_LEN samples long and advancing HOP_LEN samples per frame, in a circular buffer.
- Streams each frame oldest-first to the downstream windowing/FFT stage over a valid/ready handshake.

---
 rtl/fe_pkg.sv | 26 ++
 rtl/frame_buf.sv | 29 ++
 rtl/frame_reader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fe_pkg.sv
// Shared definitions for the feature-extractor front end: frame FSM states,
// default framing geometry reused by the FFT stage, and pointer sizing.
package fe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        FILL  = 2'd2,
        OUT   = 2'd3
    } frame_state_e;

    localparam int FE_DATA_WIDTH = 12;
    localparam int FE_FRAME_LEN  = 256;
    localparam int FE_HOP_LEN    = 128;
    localparam int FE_IDX_WIDTH  = 8;

    // Address width for a circular buffer of the given depth (at least 1 bit).
    function automatic int ptr_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/frame_buf.sv
// Circular frame storage: one synchronous write port, one combinational
// read port feeding the frame output directly.
module frame_buf
    import fe_pkg::*;
#(
    parameter int DEPTH      = FE_FRAME_LEN,
    parameter int DATA_WIDTH = FE_DATA_WIDTH,
    parameter int ADDR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Sample storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/frame_reader.sv
// Read side of the pre-emphasis FIFO: builds overlapping frames in a circular
// buffer and streams each frame oldest-first over a valid/ready handshake.
module frame_reader
    import fe_pkg::*;
#(
    parameter int DATA_WIDTH = FE_DATA_WIDTH,
    parameter int FRAME_LEN  = FE_FRAME_LEN,
    parameter int HOP_LEN    = FE_HOP_LEN,
    parameter int IDX_WIDTH  = FE_IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         empty,
    input  logic        [DATA_WIDTH-1:0] r_data,
    input  logic                         spi_en_inf_sample_sync,
    input  logic                         spi_en_fe_sample_sync,
    output logic                         r_req,
    output logic signed [DATA_WIDTH-1:0] frm_data,
    output logic                         frm_valid,
    input  logic                         frm_ready,
    output logic                         frm_first,
    output logic                         frm_last,
    output logic        [IDX_WIDTH-1:0]  frm_idx
);

    localparam int PTR_W = ptr_width(FRAME_LEN);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] HOP_CNT   = CNT_W'(HOP_LEN);
    localparam logic [PTR_W-1:0] LAST_OUT  = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    frame_state_e          state_r,    state_s;
    logic [PTR_W-1:0]      wr_ptr_r,   wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_r,   rd_ptr_s;
    logic [PTR_W-1:0]      out_cnt_r,  out_cnt_s;
    logic [CNT_W-1:0]      fill_cnt_r, fill_cnt_s;
    logic [CNT_W-1:0]      issued_r,   issued_s;
    logic                  pend_r,     pend_s;
    logic [IDX_WIDTH-1:0]  frm_idx_r,  frm_idx_s;

    logic                  en_s;
    logic                  req_s;
    logic                  xfer_s;
    logic [CNT_W-1:0]      target_s;
    logic [DATA_WIDTH-1:0] buf_data_s;

    assign en_s = spi_en_inf_sample_sync & spi_en_fe_sample_sync;

    frame_buf #(
        .DEPTH      (FRAME_LEN),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_W)
    ) u_frame_buf (
        .clk     (clk),
        .we      (pend_r),
        .wr_addr (wr_ptr_r),
        .wr_data (r_data),
        .rd_addr (rd_ptr_r),
        .rd_data (buf_data_s)
    );

    // Next-state and datapath control for the prime/fill/output sequence.
    always_comb begin
        state_s    = state_r;
        rd_ptr_s   = rd_ptr_r;
        out_cnt_s  = out_cnt_r;
        fill_cnt_s = fill_cnt_r;
        issued_s   = issued_r;
        frm_idx_s  = frm_idx_r;
        req_s      = 1'b0;
        xfer_s     = (state_r == OUT) & frm_ready;

        if (state_r == PRIME) begin
            target_s = FRAME_CNT;
        end else begin
            target_s = HOP_CNT;
        end

        // An in-flight read always lands, even after a disable; it is simply
        // never counted toward a frame.
        if (pend_r) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end

        case (state_r)
            IDLE: begin
                fill_cnt_s = CNT_ZERO;
                issued_s   = CNT_ZERO;
                frm_idx_s  = {IDX_WIDTH{1'b0}};
                if (en_s) begin
                    state_s = PRIME;
                end else begin
                    state_s = IDLE;
                end
            end
            PRIME, FILL: begin
                if (!en_s) begin
                    state_s    = IDLE;
                    fill_cnt_s = CNT_ZERO;
                    issued_s   = CNT_ZERO;
                    frm_idx_s  = {IDX_WIDTH{1'b0}};
                end else begin
                    req_s = ~empty & (issued_r < target_s);
                    if (req_s) begin
                        issued_s = issued_r + CNT_ONE;
                    end else begin
                        issued_s = issued_r;
                    end
                    // Advance on the write of the last sample, not its request.
                    if (pend_r) begin
                        fill_cnt_s = fill_cnt_r + CNT_ONE;
                        if (fill_cnt_s == target_s) begin
                            state_s    = OUT;
                            rd_ptr_s   = wr_ptr_s;
                            out_cnt_s  = PTR_ZERO;
                            fill_cnt_s = CNT_ZERO;
                            issued_s   = CNT_ZERO;
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        fill_cnt_s = fill_cnt_r;
                    end
                end
            end
            OUT: begin
                if (!en_s) begin
                    state_s    = IDLE;
                    fill_cnt_s = CNT_ZERO;
                    issued_s   = CNT_ZERO;
                    frm_idx_s  = {IDX_WIDTH{1'b0}};
                end else if (xfer_s) begin
                    rd_ptr_s  = rd_ptr_r + PTR_ONE;
                    out_cnt_s = out_cnt_r + PTR_ONE;
                    if (out_cnt_r == LAST_OUT) begin
                        state_s    = FILL;
                        frm_idx_s  = frm_idx_r + IDX_WIDTH'(1);
                        fill_cnt_s = CNT_ZERO;
                        issued_s   = CNT_ZERO;
                    end else begin
                        state_s = OUT;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        pend_s = req_s;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            out_cnt_r  <= PTR_ZERO;
            fill_cnt_r <= CNT_ZERO;
            issued_r   <= CNT_ZERO;
            pend_r     <= 1'b0;
            frm_idx_r  <= {IDX_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            out_cnt_r  <= out_cnt_s;
            fill_cnt_r <= fill_cnt_s;
            issued_r   <= issued_s;
            pend_r     <= pend_s;
            frm_idx_r  <= frm_idx_s;
        end
    end

    // Outputs are decoded from registered state only, apart from the pop
    // request, which must react to the FIFO empty flag in the same cycle.
    assign r_req     = req_s;
    assign frm_valid = (state_r == OUT);
    assign frm_first = frm_valid & (out_cnt_r == PTR_ZERO);
    assign frm_last  = frm_valid & (out_cnt_r == LAST_OUT);
    assign frm_idx   = frm_idx_r;
    assign frm_data  = frm_valid ? buf_data_s : {DATA_WIDTH{1'b0}};

endmodule
